// File: rtl/operand_fwd_unit.sv
// EX-stage operand forwarding unit.
// Each source operand resolves its value from MEM, WB or the register file
// based on register-address matches. A load in MEM raises a load-use stall.
// While EX is stalled, each operand freezes its resolved value in a hold
// register so it stays valid after the producer has retired.

module operand_fwd_lane #(
    parameter int WIDTH = 32,
    parameter int RA_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [RA_W-1:0]  ra_i,
    input  logic [WIDTH-1:0] rf_data_i,
    input  logic             ex_stall_i,
    input  logic             ex_flush_i,
    input  logic             mem_wr_en_i,
    input  logic [RA_W-1:0]  mem_rd_i,
    input  logic             mem_is_load_i,
    input  logic [WIDTH-1:0] mem_result_i,
    input  logic             wb_wr_en_i,
    input  logic [RA_W-1:0]  wb_rd_i,
    input  logic [WIDTH-1:0] wb_busw_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       sel_o,
    output logic             lu_o
);

    typedef enum logic {
        S_LIVE = 1'b0,
        S_HELD = 1'b1
    } state_e;

    localparam logic [1:0] SEL_MEM  = 2'd0;
    localparam logic [1:0] SEL_WB   = 2'd1;
    localparam logic [1:0] SEL_RF   = 2'd2;
    localparam logic [1:0] SEL_HOLD = 2'd3;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;

    logic             mem_hit, wb_hit;
    logic [WIDTH-1:0] live_data;
    logic [1:0]       live_sel;
    logic             live_lu;

    // Address matchers and the LIVE-state source priority (MEM masks WB, r0 never forwards)
    always_comb begin
        mem_hit   = mem_wr_en_i && (mem_rd_i == ra_i) && (ra_i != '0);
        wb_hit    = wb_wr_en_i  && (wb_rd_i  == ra_i) && (ra_i != '0);
        live_sel  = SEL_RF;
        live_data = rf_data_i;
        live_lu   = 1'b0;
        if (mem_hit && !mem_is_load_i) begin
            live_sel  = SEL_MEM;
            live_data = mem_result_i;
        end else if (mem_hit) begin
            // Load result not available yet: the regfile value is not meaningful
            live_lu   = 1'b1;
        end else if (wb_hit) begin
            live_sel  = SEL_WB;
            live_data = wb_busw_i;
        end
    end

    // State and hold register; reset discards any captured value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LIVE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Next state: flush wins over capture; a load-use operand stays LIVE to re-resolve
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        if (ex_flush_i) begin
            state_d = S_LIVE;
        end else begin
            case (state_q)
                S_LIVE: if (ex_stall_i && !live_lu) begin
                    state_d = S_HELD;
                    hold_d  = live_data;
                end
                S_HELD: if (!ex_stall_i) state_d = S_LIVE;
                default: state_d = S_LIVE;
            endcase
        end
    end

    // Outputs: HELD ignores the matchers entirely
    always_comb begin
        if (state_q == S_HELD) begin
            data_o = hold_q;
            sel_o  = SEL_HOLD;
            lu_o   = 1'b0;
        end else begin
            data_o = live_data;
            sel_o  = live_sel;
            lu_o   = live_lu;
        end
    end

endmodule

module operand_fwd_unit #(
    parameter int WIDTH   = 32,
    parameter int NUM_OPS = 2,
    parameter int RA_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_OPS*RA_W-1:0]  ex_src_ra,
    input  logic [NUM_OPS*WIDTH-1:0] ex_rf_data,
    input  logic                     ex_stall,
    input  logic                     ex_flush,
    input  logic                     mem_wr_en,
    input  logic [RA_W-1:0]          mem_rd,
    input  logic                     mem_is_load,
    input  logic [WIDTH-1:0]         mem_result,
    input  logic                     wb_wr_en,
    input  logic [RA_W-1:0]          wb_rd,
    input  logic [WIDTH-1:0]         wb_busw,
    output logic [NUM_OPS*WIDTH-1:0] ex_data,
    output logic [NUM_OPS*2-1:0]     fwd_sel,
    output logic                     lu_stall
);

    logic [NUM_OPS-1:0] lu_op;

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        operand_fwd_lane #(
            .WIDTH (WIDTH),
            .RA_W  (RA_W)
        ) u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .ra_i          (ex_src_ra[i*RA_W +: RA_W]),
            .rf_data_i     (ex_rf_data[i*WIDTH +: WIDTH]),
            .ex_stall_i    (ex_stall),
            .ex_flush_i    (ex_flush),
            .mem_wr_en_i   (mem_wr_en),
            .mem_rd_i      (mem_rd),
            .mem_is_load_i (mem_is_load),
            .mem_result_i  (mem_result),
            .wb_wr_en_i    (wb_wr_en),
            .wb_rd_i       (wb_rd),
            .wb_busw_i     (wb_busw),
            .data_o        (ex_data[i*WIDTH +: WIDTH]),
            .sel_o         (fwd_sel[i*2 +: 2]),
            .lu_o          (lu_op[i])
        );
    end

    // Any operand waiting on a load stalls the stage
    assign lu_stall = |lu_op;

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Directed bench for operand_fwd_unit: a 2x32 instance and a 3x16 instance.
// Expected results are queued as stimulus is applied and popped at sample time.

module tb_operand_fwd_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: NUM_OPS=2, WIDTH=32
    logic        rst_n_a, stall_a, flush_a, mwe_a, mld_a, wwe_a, lu_a;
    logic [9:0]  ra_a;
    logic [63:0] rf_a, data_a;
    logic [4:0]  mrd_a, wrd_a;
    logic [31:0] mres_a, wbus_a;
    logic [3:0]  sel_a;

    // Instance B: NUM_OPS=3, WIDTH=16
    logic        rst_n_b, stall_b, flush_b, mwe_b, mld_b, wwe_b, lu_b;
    logic [14:0] ra_b;
    logic [47:0] rf_b, data_b;
    logic [4:0]  mrd_b, wrd_b;
    logic [15:0] mres_b, wbus_b;
    logic [5:0]  sel_b;

    operand_fwd_unit #(.WIDTH(32), .NUM_OPS(2), .RA_W(5)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .ex_src_ra(ra_a), .ex_rf_data(rf_a),
        .ex_stall(stall_a), .ex_flush(flush_a), .mem_wr_en(mwe_a), .mem_rd(mrd_a),
        .mem_is_load(mld_a), .mem_result(mres_a), .wb_wr_en(wwe_a), .wb_rd(wrd_a),
        .wb_busw(wbus_a), .ex_data(data_a), .fwd_sel(sel_a), .lu_stall(lu_a)
    );

    operand_fwd_unit #(.WIDTH(16), .NUM_OPS(3), .RA_W(5)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .ex_src_ra(ra_b), .ex_rf_data(rf_b),
        .ex_stall(stall_b), .ex_flush(flush_b), .mem_wr_en(mwe_b), .mem_rd(mrd_b),
        .mem_is_load(mld_b), .mem_result(mres_b), .wb_wr_en(wwe_b), .wb_rd(wrd_b),
        .wb_busw(wbus_b), .ex_data(data_b), .fwd_sel(sel_b), .lu_stall(lu_b)
    );

    typedef struct {
        string       tag;
        bit          is_b;
        logic [63:0] data;
        logic [5:0]  sel;
        logic        lu;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic exp_a(input string tag, input logic [63:0] d, input logic [3:0] s, input logic lu);
        exp_t e;
        e.tag = tag; e.is_b = 1'b0; e.data = d; e.sel = {2'b00, s}; e.lu = lu;
        sb.push_back(e);
    endtask

    task automatic exp_b(input string tag, input logic [47:0] d, input logic [5:0] s, input logic lu);
        exp_t e;
        e.tag = tag; e.is_b = 1'b1; e.data = {16'h0, d}; e.sel = s; e.lu = lu;
        sb.push_back(e);
    endtask

    // Pop one expectation and compare it against the selected instance
    task automatic chk();
        exp_t        e;
        logic [63:0] ad;
        logic [5:0]  as;
        logic        al;
        total++;
        assert (sb.size() != 0) passed++;
        else $error("FAIL scoreboard_empty observed=0 entries expected=1");
        if (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.is_b) begin ad = {16'h0, data_b}; as = sel_b; al = lu_b; end
            else begin ad = data_a; as = {2'b00, sel_a}; al = lu_a; end
            total++;
            assert (ad === e.data) passed++;
            else $error("FAIL %s data observed=%h expected=%h", e.tag, ad, e.data);
            total++;
            assert (as === e.sel) passed++;
            else $error("FAIL %s sel observed=%b expected=%b", e.tag, as, e.sel);
            total++;
            assert (al === e.lu) passed++;
            else $error("FAIL %s lu_stall observed=%b expected=%b", e.tag, al, e.lu);
        end
    endtask

    task automatic edge_a();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n_a = 1'b0; stall_a = 0; flush_a = 0; mwe_a = 0; mld_a = 0; wwe_a = 0;
        ra_a = '0; rf_a = {32'hAAAA0001, 32'hBBBB0000}; mrd_a = 0; wrd_a = 0; mres_a = 0; wbus_a = 0;
        rst_n_b = 1'b0; stall_b = 0; flush_b = 0; mwe_b = 0; mld_b = 0; wwe_b = 0;
        ra_b = '0; rf_b = {16'h3333, 16'h2222, 16'h1111}; mrd_b = 0; wrd_b = 0; mres_b = 0; wbus_b = 0;

        // Reset state: LIVE, regfile selected, no stall
        #2;
        exp_a("reset_a", {32'hAAAA0001, 32'hBBBB0000}, 4'b1010, 1'b0); #1; chk();
        exp_b("reset_b", {16'h3333, 16'h2222, 16'h1111}, 6'b101010, 1'b0); chk();
        @(negedge clk); rst_n_a = 1'b1; rst_n_b = 1'b1;
        edge_a();

        // MEM vs WB priority
        ra_a = {5'd9, 5'd5}; rf_a = {32'h00000009, 32'h00000005};
        mwe_a = 1; mrd_a = 5; mres_a = 32'h11111111; wwe_a = 1; wrd_a = 5; wbus_a = 32'h22222222;
        exp_a("mem_over_wb", {32'h00000009, 32'h11111111}, 4'b1000, 1'b0); #1; chk();
        mwe_a = 0;
        exp_a("wb_only", {32'h00000009, 32'h22222222}, 4'b1001, 1'b0); #1; chk();

        // Register zero never forwards, even for a load
        ra_a = '0; rf_a = '0; mwe_a = 1; mld_a = 1; mrd_a = 0; wwe_a = 1; wrd_a = 0;
        exp_a("reg_zero", 64'h0, 4'b1010, 1'b0); #1; chk();
        mld_a = 0;

        // Load-use: MEM load masks a WB match on the same register
        ra_a = {5'd7, 5'd3}; rf_a = {32'h77777777, 32'h33333333};
        mwe_a = 1; mld_a = 1; mrd_a = 7; wwe_a = 1; wrd_a = 7; wbus_a = 32'h00000BAD;
        exp_a("load_use", {32'h77777777, 32'h33333333}, 4'b1010, 1'b1); #1; chk();
        stall_a = 1;
        edge_a();
        // op0 captured its regfile value; op1 stayed LIVE and now sees the load in WB
        mwe_a = 0; mld_a = 0; wwe_a = 1; wrd_a = 7; wbus_a = 32'hDEADBEEF; stall_a = 0;
        exp_a("load_in_wb", {32'hDEADBEEF, 32'h33333333}, 4'b0111, 1'b0); #1; chk();
        edge_a();
        exp_a("after_release", {32'hDEADBEEF, 32'h33333333}, 4'b0110, 1'b0); #1; chk();

        // Stall capture across several cycles with changing WB/MEM traffic
        ra_a = {5'd0, 5'd4}; rf_a = {32'h00000101, 32'h44444444};
        wwe_a = 1; wrd_a = 4; wbus_a = 32'hCAFEF00D; mwe_a = 0;
        exp_a("cap_live", {32'h00000101, 32'hCAFEF00D}, 4'b1001, 1'b0); #1; chk();
        stall_a = 1;
        edge_a();
        wrd_a = 0; wbus_a = 32'h0;
        exp_a("cap_held1", {32'h00000101, 32'hCAFEF00D}, 4'b1111, 1'b0); #1; chk();
        edge_a();
        mwe_a = 1; mrd_a = 4; mres_a = 32'h99999999; rf_a = {32'h00000202, 32'h44444444};
        exp_a("cap_held2", {32'h00000101, 32'hCAFEF00D}, 4'b1111, 1'b0); #1; chk();
        edge_a();
        exp_a("cap_held3", {32'h00000101, 32'hCAFEF00D}, 4'b1111, 1'b0); #1; chk();
        stall_a = 0; mwe_a = 0;
        exp_a("cap_pre_edge", {32'h00000101, 32'hCAFEF00D}, 4'b1111, 1'b0); #1; chk();
        edge_a();
        exp_a("cap_live_again", {32'h00000202, 32'h44444444}, 4'b1010, 1'b0); #1; chk();

        // Flush during stall: flush wins over holding
        ra_a = {5'd0, 5'd6}; wwe_a = 1; wrd_a = 6; wbus_a = 32'h12345678; stall_a = 1;
        exp_a("fl_live", {32'h00000202, 32'h12345678}, 4'b1001, 1'b0); #1; chk();
        edge_a();
        exp_a("fl_held", {32'h00000202, 32'h12345678}, 4'b1111, 1'b0); #1; chk();
        flush_a = 1; wbus_a = 32'h55555555;
        exp_a("fl_pre_edge", {32'h00000202, 32'h12345678}, 4'b1111, 1'b0); #1; chk();
        edge_a();
        exp_a("fl_after", {32'h00000202, 32'h55555555}, 4'b1001, 1'b0); #1; chk();
        flush_a = 0;

        // Async reset mid-HELD, between clock edges
        edge_a();
        wbus_a = 32'h66666666;
        exp_a("rst_held", {32'h00000202, 32'h55555555}, 4'b1111, 1'b0); #1; chk();
        #1 rst_n_a = 1'b0;
        exp_a("rst_async", {32'h00000202, 32'h66666666}, 4'b1001, 1'b0); #1; chk();
        rst_n_a = 1'b1;
        exp_a("rst_release", {32'h00000202, 32'h66666666}, 4'b1001, 1'b0); #1; chk();
        stall_a = 0;

        // Instance B: three independent 16-bit slices
        edge_a();
        ra_b = {5'd3, 5'd2, 5'd1}; rf_b = {16'h3333, 16'h2222, 16'h1111};
        mwe_b = 1; mrd_b = 3; mres_b = 16'h1234; wwe_b = 1; wrd_b = 2; wbus_b = 16'hBEEF;
        exp_b("b_live", {16'h1234, 16'hBEEF, 16'h1111}, 6'b000110, 1'b0); #1; chk();
        stall_b = 1;
        edge_a();
        mwe_b = 0; wwe_b = 0; rf_b = {16'h3030, 16'h2020, 16'h1010};
        exp_b("b_held", {16'h1234, 16'hBEEF, 16'h1111}, 6'b111111, 1'b0); #1; chk();
        #1 rst_n_b = 1'b0;
        exp_b("b_rst_async", {16'h3030, 16'h2020, 16'h1010}, 6'b101010, 1'b0); #1; chk();
        rst_n_b = 1'b1; stall_b = 0;
        mwe_b = 1; mld_b = 1; mrd_b = 3; wwe_b = 1; wrd_b = 2; wbus_b = 16'hBEEF;
        exp_b("b_load_use", {16'h3030, 16'hBEEF, 16'h1010}, 6'b100110, 1'b1); #1; chk();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
